// File: rtl/i2c_bridge_pkg.sv
// Shared types and constants for the I2C-to-UART bridge control path.
// Latency: n/a (types only).
// Backpressure: n/a.
package i2c_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEL,
    S_IGN
  } i2c_state_t;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_WAIT_BUSY,
    U_WAIT_DONE
  } uart_state_t;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h27;

endpackage

// File: rtl/bridge_fifo.sv
// Byte FIFO with wrap-around pointers; level = write pointer minus read pointer.
// Latency: a push is visible in level/dout the cycle after it is presented.
// Backpressure: pushes while full and pops while empty are ignored.
module bridge_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // The extra pointer MSB separates "full" from "empty" when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/i2c_uart_bridge_ctrl.sv
// Filters I2C writes to our address, queues data bytes, and paces them into the UART.
// Latency: ack one cycle after each event; byte pulse at N gives uart_tx_start at N+2.
// Backpressure: FIFO full NACKs and drops the byte (sticky overflow); UART busy stalls pops.
module i2c_uart_bridge_ctrl
  import i2c_bridge_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i2c_addr_valid,
  input  logic [6:0]                    i2c_addr,
  input  logic                          i2c_rw,
  input  logic                          i2c_byte_valid,
  input  logic [7:0]                    i2c_byte,
  input  logic                          i2c_stop,
  output logic                          i2c_ack,
  output logic                          active,
  output logic [7:0]                    uart_tx_data,
  output logic                          uart_tx_start,
  input  logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  i2c_state_t  i2c_state, i2c_next;
  uart_state_t u_state, u_next;

  logic       ack_next;
  logic       push;
  logic       pop;
  logic       ovf_set;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (i2c_byte),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign active        = (i2c_state == S_SEL);
  assign uart_tx_start = (u_state == U_START);

  // I2C-side state, ack level and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_state <= S_IDLE;
      i2c_ack   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      i2c_state <= i2c_next;
      i2c_ack   <= ack_next;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // I2C-side decode: address beats stop (repeated START), stop beats data.
  // Fullness is judged before any same-cycle pop, so a full FIFO always refuses.
  always_comb begin
    i2c_next = i2c_state;
    ack_next = i2c_ack;
    push     = 1'b0;
    ovf_set  = 1'b0;
    if (i2c_addr_valid) begin
      if ((i2c_addr == SLAVE_ADDR) && !i2c_rw) begin
        i2c_next = S_SEL;
        ack_next = 1'b1;
      end else begin
        i2c_next = S_IGN;
        ack_next = 1'b0;
      end
    end else if (i2c_stop) begin
      i2c_next = S_IDLE;
    end else if (i2c_byte_valid) begin
      if (i2c_state == S_SEL) begin
        if (!fifo_full) begin
          push     = 1'b1;
          ack_next = 1'b1;
        end else begin
          ack_next = 1'b0;
          ovf_set  = 1'b1;
        end
      end else begin
        ack_next = 1'b0;
      end
    end
  end

  // UART-side state and the held transmit byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_state      <= U_IDLE;
      uart_tx_data <= 8'h00;
    end else begin
      u_state <= u_next;
      if (pop) uart_tx_data <= fifo_dout;
    end
  end

  // UART-side sequencing: pop, pulse start, then track one full busy window.
  always_comb begin
    u_next = u_state;
    pop    = 1'b0;
    case (u_state)
      U_IDLE: begin
        if (!fifo_empty && !uart_tx_busy) begin
          pop    = 1'b1;
          u_next = U_START;
        end
      end
      U_START:     u_next = U_WAIT_BUSY;
      U_WAIT_BUSY: if (uart_tx_busy)  u_next = U_WAIT_DONE;
      U_WAIT_DONE: if (!uart_tx_busy) u_next = U_IDLE;
      default:     u_next = U_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_uart_bridge_ctrl.sv
module tb_i2c_uart_bridge_ctrl;

  localparam int         DEPTH   = 8;
  localparam logic [6:0] MY_ADDR = 7'h27;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i2c_addr_valid;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic       i2c_byte_valid;
  logic [7:0] i2c_byte;
  logic       i2c_stop;
  logic       i2c_ack;
  logic       active;
  logic [7:0] uart_tx_data;
  logic       uart_tx_start;
  logic       uart_tx_busy;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       ovf_clr;

  int         total = 0;
  int         bad = 0;
  logic [7:0] rx_q[$];
  int         busy_len = 3;
  bit         uart_hold = 1'b0;

  always #5 clk = ~clk;

  i2c_uart_bridge_ctrl #(.SLAVE_ADDR(MY_ADDR), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i2c_addr_valid (i2c_addr_valid),
    .i2c_addr       (i2c_addr),
    .i2c_rw         (i2c_rw),
    .i2c_byte_valid (i2c_byte_valid),
    .i2c_byte       (i2c_byte),
    .i2c_stop       (i2c_stop),
    .i2c_ack        (i2c_ack),
    .active         (active),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_start  (uart_tx_start),
    .uart_tx_busy   (uart_tx_busy),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr)
  );

  // UART transmitter model: captures each started byte, busy from the next cycle.
  initial begin : uart_model
    int busy_cnt;
    busy_cnt = 0;
    uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (uart_tx_start === 1'b1) begin
        rx_q.push_back(uart_tx_data);
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      uart_tx_busy = uart_hold || (busy_cnt > 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    i2c_addr = a; i2c_rw = rw; i2c_addr_valid = 1'b1;
    tick(1);
    i2c_addr_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i2c_byte = b; i2c_byte_valid = 1'b1;
    tick(1);
    i2c_byte_valid = 1'b0;
  endtask

  task automatic send_stop();
    i2c_stop = 1'b1;
    tick(1);
    i2c_stop = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    total++;
    if (rx_q.size() < n) begin
      bad++;
      $display("FAIL wait_rx: got %0d bytes, need %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    total += 6;
    if (i2c_ack !== 1'b0)       begin bad++; $display("FAIL rst_ack: %b exp 0", i2c_ack); end
    if (active !== 1'b0)        begin bad++; $display("FAIL rst_active: %b exp 0", active); end
    if (uart_tx_data !== 8'h00) begin bad++; $display("FAIL rst_data: %h exp 00", uart_tx_data); end
    if (uart_tx_start !== 1'b0) begin bad++; $display("FAIL rst_start: %b exp 0", uart_tx_start); end
    if (fifo_level !== 4'd0)    begin bad++; $display("FAIL rst_level: %0d exp 0", fifo_level); end
    if (overflow !== 1'b0)      begin bad++; $display("FAIL rst_ovf: %b exp 0", overflow); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_write();
    int base;
    base = rx_q.size();
    send_addr(MY_ADDR, 1'b0);
    total += 2;
    if (i2c_ack !== 1'b1) begin bad++; $display("FAIL sw_addr_ack: %b exp 1", i2c_ack); end
    if (active !== 1'b1)  begin bad++; $display("FAIL sw_active: %b exp 1", active); end
    send_byte(8'h07);
    total += 3;
    if (i2c_ack !== 1'b1)       begin bad++; $display("FAIL sw_byte_ack: %b exp 1", i2c_ack); end
    if (fifo_level !== 4'd1)    begin bad++; $display("FAIL sw_level1: %0d exp 1", fifo_level); end
    if (uart_tx_start !== 1'b0) begin bad++; $display("FAIL sw_early_start: %b exp 0", uart_tx_start); end
    tick(1);
    total += 3;
    if (uart_tx_start !== 1'b1) begin bad++; $display("FAIL sw_start: %b exp 1", uart_tx_start); end
    if (uart_tx_data !== 8'h07) begin bad++; $display("FAIL sw_data: %h exp 07", uart_tx_data); end
    if (fifo_level !== 4'd0)    begin bad++; $display("FAIL sw_level0: %0d exp 0", fifo_level); end
    send_stop();
    total += 2;
    if (i2c_ack !== 1'b1) begin bad++; $display("FAIL sw_stop_ack_hold: %b exp 1", i2c_ack); end
    if (active !== 1'b0)  begin bad++; $display("FAIL sw_stop_active: %b exp 0", active); end
    wait_rx(base + 1, 50);
    total++;
    if (rx_q.size() > base && rx_q[base] !== 8'h07) begin
      bad++; $display("FAIL sw_rx: %h exp 07", rx_q[base]);
    end
    tick(10);
  endtask

  task automatic test_other_addr();
    int base;
    base = rx_q.size();
    send_addr(7'h28, 1'b0);
    total += 2;
    if (i2c_ack !== 1'b0) begin bad++; $display("FAIL oa_ack: %b exp 0", i2c_ack); end
    if (active !== 1'b0)  begin bad++; $display("FAIL oa_active: %b exp 0", active); end
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom));
      total += 2;
      if (i2c_ack !== 1'b0)    begin bad++; $display("FAIL oa_byte_ack: %b exp 0", i2c_ack); end
      if (fifo_level !== 4'd0) begin bad++; $display("FAIL oa_level: %0d exp 0", fifo_level); end
    end
    tick(20);
    total++;
    if (rx_q.size() != base) begin bad++; $display("FAIL oa_no_start: %0d bytes exp %0d", rx_q.size(), base); end
    send_stop();
  endtask

  task automatic test_read();
    int base;
    base = rx_q.size();
    send_addr(MY_ADDR, 1'b1);
    total += 2;
    if (i2c_ack !== 1'b0) begin bad++; $display("FAIL rd_ack: %b exp 0", i2c_ack); end
    if (active !== 1'b0)  begin bad++; $display("FAIL rd_active: %b exp 0", active); end
    send_byte(8'h5A);
    total += 2;
    if (i2c_ack !== 1'b0)    begin bad++; $display("FAIL rd_byte_ack: %b exp 0", i2c_ack); end
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL rd_level: %0d exp 0", fifo_level); end
    tick(10);
    total++;
    if (rx_q.size() != base) begin bad++; $display("FAIL rd_no_start: %0d exp %0d", rx_q.size(), base); end
    send_stop();
  endtask

  task automatic test_overflow();
    int base;
    int model_level;
    logic exp_ack;
    base = rx_q.size();
    model_level = 0;
    uart_hold = 1'b1;
    tick(3);
    send_addr(MY_ADDR, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i));
      exp_ack = (model_level < DEPTH);
      if (exp_ack) model_level++;
      total++;
      if (i2c_ack !== exp_ack) begin bad++; $display("FAIL ov_ack byte %0d: %b exp %b", i, i2c_ack, exp_ack); end
      tick(1);
    end
    total += 2;
    if (overflow !== 1'b1)                 begin bad++; $display("FAIL ov_flag: %b exp 1", overflow); end
    if (fifo_level !== 4'(model_level))    begin bad++; $display("FAIL ov_level: %0d exp %0d", fifo_level, model_level); end
    // dropped byte with a clear in the same cycle: the set must win
    i2c_byte = 8'h0A; i2c_byte_valid = 1'b1; ovf_clr = 1'b1;
    tick(1);
    i2c_byte_valid = 1'b0; ovf_clr = 1'b0;
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ov_set_wins: %b exp 1", overflow); end
    if (i2c_ack !== 1'b0)  begin bad++; $display("FAIL ov_clr_ack: %b exp 0", i2c_ack); end
    uart_hold = 1'b0;
    wait_rx(base + 8, 300);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rx_q.size() <= base + i || rx_q[base + i] !== 8'(i + 1)) begin
        bad++; $display("FAIL ov_order idx %0d: %h exp %h", i,
                        (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx, 8'(i + 1));
      end
    end
    tick(20);
    total++;
    if (rx_q.size() != base + 8) begin bad++; $display("FAIL ov_count: %0d exp %0d", rx_q.size() - base, 8); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ov_clr: %b exp 0", overflow); end
    send_stop();
  endtask

  task automatic test_repeated_start();
    int base;
    base = rx_q.size();
    send_addr(MY_ADDR, 1'b0);
    send_byte(8'hA1);
    total++;
    if (i2c_ack !== 1'b1) begin bad++; $display("FAIL rs_first_ack: %b exp 1", i2c_ack); end
    tick(2);
    send_addr(7'h30, 1'b0);
    total += 2;
    if (i2c_ack !== 1'b0) begin bad++; $display("FAIL rs_addr_ack: %b exp 0", i2c_ack); end
    if (active !== 1'b0)  begin bad++; $display("FAIL rs_active: %b exp 0", active); end
    send_byte(8'hB2);
    total++;
    if (i2c_ack !== 1'b0) begin bad++; $display("FAIL rs_byte_ack: %b exp 0", i2c_ack); end
    send_stop();
    send_byte(8'hB3);
    total += 2;
    if (i2c_ack !== 1'b0) begin bad++; $display("FAIL rs_idle_ack: %b exp 0", i2c_ack); end
    if (active !== 1'b0)  begin bad++; $display("FAIL rs_idle_active: %b exp 0", active); end
    wait_rx(base + 1, 50);
    tick(20);
    total += 2;
    if (rx_q.size() != base + 1) begin bad++; $display("FAIL rs_count: %0d exp 1", rx_q.size() - base); end
    if (rx_q.size() > base && rx_q[base] !== 8'hA1) begin bad++; $display("FAIL rs_data: %h exp a1", rx_q[base]); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = rx_q.size();
    busy_len = 25;
    send_addr(MY_ADDR, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    tick(3);
    total += 2;
    if (fifo_level !== 4'd3)     begin bad++; $display("FAIL rm_level_pre: %0d exp 3", fifo_level); end
    if (rx_q.size() != base + 1) begin bad++; $display("FAIL rm_inflight: %0d exp 1", rx_q.size() - base); end
    rst_n = 1'b0;
    #1;
    total += 6;
    if (i2c_ack !== 1'b0)       begin bad++; $display("FAIL rm_ack: %b exp 0", i2c_ack); end
    if (active !== 1'b0)        begin bad++; $display("FAIL rm_active: %b exp 0", active); end
    if (uart_tx_data !== 8'h00) begin bad++; $display("FAIL rm_data: %h exp 00", uart_tx_data); end
    if (uart_tx_start !== 1'b0) begin bad++; $display("FAIL rm_start: %b exp 0", uart_tx_start); end
    if (fifo_level !== 4'd0)    begin bad++; $display("FAIL rm_level: %0d exp 0", fifo_level); end
    if (overflow !== 1'b0)      begin bad++; $display("FAIL rm_ovf: %b exp 0", overflow); end
    tick(2);
    rst_n = 1'b1;
    busy_len = 3;
    tick(60);
    total += 2;
    if (rx_q.size() != base + 1) begin bad++; $display("FAIL rm_no_start: %0d exp 1", rx_q.size() - base); end
    if (fifo_level !== 4'd0)     begin bad++; $display("FAIL rm_level_post: %0d exp 0", fifo_level); end
  endtask

  task automatic test_random();
    int base;
    int nb;
    logic [7:0] exp_q[$];
    logic [6:0] a;
    logic rw, sel;
    logic [7:0] b;
    base = rx_q.size();
    busy_len = 3;
    for (int t = 0; t < 8; t++) begin
      a   = ($urandom_range(0, 1) == 1) ? MY_ADDR : 7'($urandom);
      rw  = ($urandom_range(0, 3) == 0);
      sel = (a == MY_ADDR) && !rw;
      send_addr(a, rw);
      total += 2;
      if (i2c_ack !== sel) begin bad++; $display("FAIL rnd_addr_ack t%0d: %b exp %b", t, i2c_ack, sel); end
      if (active !== sel)  begin bad++; $display("FAIL rnd_active t%0d: %b exp %b", t, active, sel); end
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom);
        send_byte(b);
        total++;
        if (i2c_ack !== sel) begin bad++; $display("FAIL rnd_byte_ack t%0d: %b exp %b", t, i2c_ack, sel); end
        if (sel) exp_q.push_back(b);
        tick(12);
      end
      send_stop();
      tick(2);
    end
    wait_rx(base + exp_q.size(), 500);
    tick(20);
    total++;
    if (rx_q.size() != base + exp_q.size()) begin
      bad++; $display("FAIL rnd_count: %0d exp %0d", rx_q.size() - base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      total++;
      if (rx_q.size() <= base + i || rx_q[base + i] !== exp_q[i]) begin
        bad++; $display("FAIL rnd_data idx %0d: %h exp %h", i,
                        (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i2c_addr_valid = 1'b0;
    i2c_addr = '0;
    i2c_rw = 1'b0;
    i2c_byte_valid = 1'b0;
    i2c_byte = '0;
    i2c_stop = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_single_write();
    test_other_addr();
    test_read();
    test_overflow();
    test_repeated_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
